// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue/writeback stage.
// Holds the datapath widths, instruction field positions, opcode constants,
// the sequencer state type and a small opcode classification helper.
package alu_pkg;

    localparam int unsigned DATA_W  = 8;
    localparam int unsigned RA_W    = 2;
    localparam int unsigned NREGS   = 2 ** RA_W;
    localparam int unsigned OP_W    = 4;
    localparam int unsigned INSTR_W = OP_W + 2 * RA_W + DATA_W;

    // Instruction layout: op | rd | rs1 | imm (rs2 aliases the top of imm)
    localparam int unsigned IMM_LSB = 0;
    localparam int unsigned RS2_LSB = DATA_W - RA_W;
    localparam int unsigned RS1_LSB = DATA_W;
    localparam int unsigned RD_LSB  = DATA_W + RA_W;
    localparam int unsigned OP_LSB  = DATA_W + 2 * RA_W;

    typedef logic [OP_W-1:0] opcode_t;

    localparam opcode_t OP_ADD  = 4'h0;
    localparam opcode_t OP_SUB  = 4'h1;
    localparam opcode_t OP_MUL  = 4'h2;
    localparam opcode_t OP_DIV  = 4'h3;
    localparam opcode_t OP_AND  = 4'h4;
    localparam opcode_t OP_OR   = 4'h5;
    localparam opcode_t OP_XOR  = 4'h6;
    localparam opcode_t OP_NAND = 4'h7;
    localparam opcode_t OP_NOR  = 4'h8;
    localparam opcode_t OP_XNOR = 4'h9;
    localparam opcode_t OP_LDI  = 4'hE;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        EXEC = 2'd2,
        WB   = 2'd3
    } seq_state_t;

    // True for opcodes executed by the external ALU
    function automatic logic is_alu_op(input opcode_t op);
        return op <= OP_XNOR;
    endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Instruction issue channel (valid/ready handshake plus instruction word).
//   instr_valid : instruction present (master -> slave)
//   instr_ready : slave can accept    (slave -> master)
//   instr       : op[15:12] rd[11:10] rs1[9:8] imm/rs2[7:0]
interface alu_sequencer_if;
    import alu_pkg::*;

    logic               instr_valid;
    logic               instr_ready;
    logic [INSTR_W-1:0] instr;

    modport master (output instr_valid, output instr, input instr_ready);
    modport slave  (input instr_valid, input instr, output instr_ready);

endinterface

// File: rtl/alu_regfile.sv
// Small register file for the ALU sequencer.
//   clk, rst            : clock, synchronous active-high reset (clears all)
//   wr_en/addr/data     : single synchronous write port
//   rs1_*, rs2_*, dbg_* : three combinational read ports
module alu_regfile
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [RA_W-1:0]   wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [RA_W-1:0]   rs1_addr,
    output logic [DATA_W-1:0] rs1_data,
    input  logic [RA_W-1:0]   rs2_addr,
    output logic [DATA_W-1:0] rs2_data,
    input  logic [RA_W-1:0]   dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    logic [DATA_W-1:0] mem [NREGS];

    // Storage with synchronous clear
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rs1_data = mem[rs1_addr];
    assign rs2_data = mem[rs2_addr];
    assign dbg_data = mem[dbg_addr];

endmodule

// File: rtl/alu_sequencer.sv
// Issue/writeback stage in front of an 8-bit combinational ALU.
// Accepts one instruction per four cycles (IDLE->READ->EXEC->WB), reads
// operands from the register file, drives the ALU from registers, and writes
// the ALU result (or an LDI immediate) back, updating zero/carry flags.
//   clk, rst                   : clock, synchronous active-high reset
//   bus (slave)                : instr_valid / instr_ready / instr
//   alu_a, alu_b, alu_sel      : registered ALU operands and select
//   alu_result, alu_carry      : ALU outputs
//   wb_valid, wb_addr, wb_data : writeback pulse and payload
//   flag_z, flag_c             : status flags
//   err_illegal, err_div0      : error pulses
//   dbg_addr, dbg_data         : combinational register file peek
module alu_sequencer
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    alu_sequencer_if.slave    bus,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_sel,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_carry,
    output logic              wb_valid,
    output logic [RA_W-1:0]   wb_addr,
    output logic [DATA_W-1:0] wb_data,
    output logic              flag_z,
    output logic              flag_c,
    output logic              err_illegal,
    output logic              err_div0,
    input  logic [RA_W-1:0]   dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    seq_state_t         state;
    seq_state_t         state_next;
    logic [INSTR_W-1:0] instr_q;
    opcode_t            op;
    logic [RA_W-1:0]    rd;
    logic [RA_W-1:0]    rs1;
    logic [RA_W-1:0]    rs2;
    logic [DATA_W-1:0]  imm;
    logic [DATA_W-1:0]  rs1_data;
    logic [DATA_W-1:0]  rs2_data;
    logic               carry_q;
    logic               take;
    logic               load_ops;
    logic               capture;
    logic               commit;

    assign op  = instr_q[OP_LSB +: OP_W];
    assign rd  = instr_q[RD_LSB +: RA_W];
    assign rs1 = instr_q[RS1_LSB +: RA_W];
    assign rs2 = instr_q[RS2_LSB +: RA_W];
    assign imm = instr_q[IMM_LSB +: DATA_W];

    assign bus.instr_ready = (state == IDLE) && !rst;
    assign take            = bus.instr_valid && bus.instr_ready;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and per-state datapath strobes
    always_comb begin
        state_next = state;
        load_ops   = 1'b0;
        capture    = 1'b0;
        commit     = 1'b0;
        case (state)
            IDLE: if (take) state_next = READ;
            READ: begin
                load_ops   = (op != OP_LDI);
                state_next = EXEC;
            end
            EXEC: begin
                capture    = 1'b1;
                state_next = WB;
            end
            WB: begin
                commit     = wb_valid;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath: latch instruction, drive ALU, resolve outcome, update flags.
    // The outcome is resolved at the end of EXEC so the pulses are visible
    // for exactly the WB cycle; the register and flags change at the end of WB.
    always_ff @(posedge clk) begin
        if (rst) begin
            instr_q     <= '0;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_sel     <= '0;
            carry_q     <= 1'b0;
            wb_valid    <= 1'b0;
            wb_addr     <= '0;
            wb_data     <= '0;
            err_illegal <= 1'b0;
            err_div0    <= 1'b0;
            flag_z      <= 1'b0;
            flag_c      <= 1'b0;
        end else begin
            wb_valid    <= 1'b0;
            err_illegal <= 1'b0;
            err_div0    <= 1'b0;

            if (take) begin
                instr_q <= bus.instr;
            end

            if (load_ops) begin
                alu_a   <= rs1_data;
                alu_b   <= rs2_data;
                alu_sel <= op;
            end

            if (capture) begin
                wb_addr <= rd;
                carry_q <= alu_carry;
                if (op == OP_LDI) begin
                    wb_valid <= 1'b1;
                    wb_data  <= imm;
                end else if (!is_alu_op(op)) begin
                    err_illegal <= 1'b1;
                end else if ((op == OP_DIV) && (alu_b == '0)) begin
                    err_div0 <= 1'b1;
                end else begin
                    wb_valid <= 1'b1;
                    wb_data  <= alu_result;
                end
            end

            // LDI writes the register but leaves the flags alone
            if (commit && (op != OP_LDI)) begin
                flag_z <= (wb_data == '0);
                if (op == OP_ADD) begin
                    flag_c <= carry_q;
                end
            end
        end
    end

    alu_regfile u_regfile (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (commit),
        .wr_addr  (wb_addr),
        .wr_data  (wb_data),
        .rs1_addr (rs1),
        .rs1_data (rs1_data),
        .rs2_addr (rs2),
        .rs2_data (rs2_data),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

endmodule
